// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the shared single-port memory.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_fetch;
   logic        stall_pipe;
   logic        err;

   // arbiter side
   modport slave (
      input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
             stall_fetch, stall_pipe, err
   );

   // pipeline + memory side
   modport master (
      output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
             stall_fetch, stall_pipe, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and MEM-stage
// data accesses. Data has priority; an access in flight is never preempted.
// A watchdog aborts any access that waits WAIT_MAX cycles without mem_ready.
module mem_arbiter #(
   parameter int WAIT_MAX = 15
) (
   input  logic          Eclk,
   input  logic          Erst_n,
   mem_arbiter_if.slave  bus
);

   localparam logic [3:0] WMAX = 4'(WAIT_MAX);

   typedef enum logic [2:0] {IDLE, DACC, DRESP, IACC, IRESP} state_t;

   state_t     state;
   logic [3:0] wcnt;

   // Stalls follow the live requests so the pipeline freezes in the same cycle it asks.
   assign bus.stall_pipe  = (bus.d_read | bus.d_write) & ~bus.d_valid;
   assign bus.stall_fetch = bus.stall_pipe | (bus.if_req & ~bus.if_valid);

   // Arbitration FSM; all memory-side and response outputs are registered here.
   always_ff @(posedge Eclk or negedge Erst_n) begin
      if (!Erst_n) begin
         state         <= IDLE;
         wcnt          <= 4'd0;
         bus.if_valid  <= 1'b0;
         bus.d_valid   <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.err       <= 1'b0;
         bus.if_rdata  <= 32'h0;
         bus.d_rdata   <= 32'h0;
         bus.mem_addr  <= 32'h0;
         bus.mem_wdata <= 32'h0;
      end else begin
         bus.if_valid <= 1'b0;
         bus.d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.d_read || bus.d_write) begin
                  // store wins when both load and store are asserted
                  state         <= DACC;
                  wcnt          <= 4'd0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= bus.d_write;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
               end else if (bus.if_req) begin
                  state         <= IACC;
                  wcnt          <= 4'd0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= bus.if_addr;
                  bus.mem_wdata <= 32'h0;
               end
            end
            DACC: begin
               if (bus.mem_ready) begin
                  if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
                  state       <= DRESP;
                  bus.d_valid <= 1'b1;
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
               end else if (wcnt == WMAX) begin
                  state       <= DRESP;
                  bus.err     <= 1'b1;
                  bus.d_rdata <= 32'h0;
                  bus.d_valid <= 1'b1;
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            IACC: begin
               if (bus.mem_ready) begin
                  state        <= IRESP;
                  bus.if_rdata <= bus.mem_rdata;
                  bus.if_valid <= 1'b1;
                  bus.mem_req  <= 1'b0;
               end else if (wcnt == WMAX) begin
                  state        <= IRESP;
                  bus.err      <= 1'b1;
                  bus.if_rdata <= 32'h0;
                  bus.if_valid <= 1'b1;
                  bus.mem_req  <= 1'b0;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            DRESP:   state <= IDLE;
            IRESP:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory responder with programmable wait, a word-array
// reference memory, and per-scenario tasks with randomized traffic at the end.
module tb_mem_arbiter;

   localparam int WAIT_MAX = 15;

   logic Eclk = 1'b0;
   logic Erst_n = 1'b0;
   always #5 Eclk = ~Eclk;

   mem_arbiter_if bus();

   mem_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
      .Eclk   (Eclk),
      .Erst_n (Erst_n),
      .bus    (bus)
   );

   int nvec = 0;
   int nmis = 0;

   // memory seen by the DUT and the bench's own expectation of its contents
   logic [31:0] mem_arr [0:255];
   logic [31:0] ref_mem [0:255];
   int rsp_wait = 0;
   int req_cnt = 0;

   // responder: ready once the request has been held rsp_wait cycles
   always_comb begin
      bus.mem_ready = bus.mem_req && (req_cnt >= rsp_wait);
      bus.mem_rdata = bus.mem_req ? mem_arr[bus.mem_addr[9:2]] : 32'hDEAD_BEEF;
   end

   // count how long the current request has been waiting
   always @(posedge Eclk) begin
      if (!bus.mem_req || bus.mem_ready) req_cnt <= 0;
      else req_cnt <= req_cnt + 1;
   end

   // Drive one request until its valid pulse; returns observations only.
   task automatic run_xact(input bit d, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int w, output int lat,
                           output logic [31:0] rdat, output int we_cyc, output int req_cyc,
                           output int stall_hi, output logic stall_v);
      rsp_wait    = w;
      bus.d_read  = d & rd;
      bus.d_write = d & wr;
      bus.if_req  = !d;
      bus.d_addr  = addr;
      bus.if_addr = addr;
      bus.d_wdata = wdata;
      lat = -1; rdat = 32'h0; we_cyc = 0; req_cyc = 0; stall_hi = 0; stall_v = 1'b1;
      #1;
      if (d ? bus.stall_pipe : bus.stall_fetch) stall_hi++;
      for (int n = 1; n <= 40; n++) begin
         @(posedge Eclk); #1;
         if (d ? bus.d_valid : bus.if_valid) begin
            lat     = n;
            rdat    = d ? bus.d_rdata : bus.if_rdata;
            stall_v = d ? bus.stall_pipe : bus.stall_fetch;
            break;
         end
         if (d ? bus.stall_pipe : bus.stall_fetch) stall_hi++;
         if (bus.mem_req) begin
            req_cyc++;
            if (bus.mem_we && bus.mem_wdata == wdata && bus.mem_addr == addr) we_cyc++;
            if (bus.mem_ready && bus.mem_we) mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
         end
      end
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.if_req = 1'b0;
      @(posedge Eclk); #1;
   endtask

   task automatic test_reset();
      Erst_n = 1'b0;
      repeat (2) @(posedge Eclk);
      #1;
      nvec++; if (bus.mem_req !== 1'b0) begin nmis++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
      nvec++; if (bus.mem_we !== 1'b0) begin nmis++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
      nvec++; if ({bus.if_valid, bus.d_valid, bus.err} !== 3'b000) begin nmis++; $display("FAIL rst_flags got=%b exp=000", {bus.if_valid, bus.d_valid, bus.err}); end
      nvec++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin nmis++; $display("FAIL rst_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata}); end
      nvec++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin nmis++; $display("FAIL rst_mem_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
      nvec++; if ({bus.stall_pipe, bus.stall_fetch} !== 2'b00) begin nmis++; $display("FAIL rst_stall got=%b exp=00", {bus.stall_pipe, bus.stall_fetch}); end
      Erst_n = 1'b1;
      @(posedge Eclk); #1;
   endtask

   task automatic test_fetch();
      int lat, we, rq, sh; logic [31:0] rd; logic sv;
      mem_arr[4] = 32'h8C010004; ref_mem[4] = 32'h8C010004;
      run_xact(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, lat, rd, we, rq, sh, sv);
      nvec++; if (lat !== 2) begin nmis++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
      nvec++; if (rd !== 32'h8C010004) begin nmis++; $display("FAIL fetch_rdata got=%h exp=8c010004", rd); end
      nvec++; if (sv !== 1'b0) begin nmis++; $display("FAIL fetch_stall_in_iresp got=%b exp=0", sv); end
      nvec++; if (sh !== 2) begin nmis++; $display("FAIL fetch_stall_cycles got=%0d exp=2", sh); end
      nvec++; if (we !== 0 || rq !== 1) begin nmis++; $display("FAIL fetch_mem_cycles we=%0d req=%0d exp we=0 req=1", we, rq); end
   endtask

   task automatic test_priority();
      int dv_n = -1, iv_n = -1; logic [31:0] drd = 32'h0, ird = 32'h0, gaddr = 32'hx; logic gwe = 1'bx;
      mem_arr[16] = 32'h1234; ref_mem[16] = 32'h1234;
      rsp_wait = 0;
      bus.d_read = 1'b1; bus.d_addr = 32'h40; bus.if_req = 1'b1; bus.if_addr = 32'h10;
      for (int n = 1; n <= 20; n++) begin
         @(posedge Eclk); #1;
         if (n == 1) begin gaddr = bus.mem_addr; gwe = bus.mem_we; end
         if (bus.d_valid && dv_n < 0) begin dv_n = n; drd = bus.d_rdata; bus.d_read = 1'b0; end
         if (bus.if_valid) begin iv_n = n; ird = bus.if_rdata; bus.if_req = 1'b0; break; end
      end
      bus.d_read = 1'b0; bus.if_req = 1'b0;
      @(posedge Eclk); #1;
      nvec++; if (gaddr !== 32'h40 || gwe !== 1'b0) begin nmis++; $display("FAIL prio_first_grant addr=%h we=%b exp addr=40 we=0", gaddr, gwe); end
      nvec++; if (dv_n !== 2) begin nmis++; $display("FAIL prio_d_latency got=%0d exp=2", dv_n); end
      nvec++; if (drd !== 32'h1234) begin nmis++; $display("FAIL prio_d_rdata got=%h exp=1234", drd); end
      nvec++; if (iv_n !== 5) begin nmis++; $display("FAIL prio_fetch_after got=%0d exp=5", iv_n); end
      nvec++; if (ird !== 32'h8C010004) begin nmis++; $display("FAIL prio_if_rdata got=%h exp=8c010004", ird); end
   endtask

   task automatic test_write_wait();
      int lat, we, rq, sh; logic [31:0] rd, prev; logic sv;
      prev = bus.d_rdata;
      run_xact(1'b1, 1'b0, 1'b1, 32'h20, 32'hAA, 3, lat, rd, we, rq, sh, sv);
      ref_mem[8] = 32'hAA;
      nvec++; if (lat !== 5) begin nmis++; $display("FAIL wr_latency got=%0d exp=5", lat); end
      nvec++; if (we !== 4 || rq !== 4) begin nmis++; $display("FAIL wr_we_cycles we=%0d req=%0d exp=4", we, rq); end
      nvec++; if (rd !== prev) begin nmis++; $display("FAIL wr_d_rdata_kept got=%h exp=%h", rd, prev); end
      nvec++; if (sh !== 5 || sv !== 1'b0) begin nmis++; $display("FAIL wr_stall_pipe hi=%0d at_valid=%b exp hi=5 at_valid=0", sh, sv); end
      run_xact(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1, lat, rd, we, rq, sh, sv);
      nvec++; if (rd !== ref_mem[8] || lat !== 3) begin nmis++; $display("FAIL wr_readback got=%h lat=%0d exp=%h lat=3", rd, lat, ref_mem[8]); end
   endtask

   task automatic test_read_write_both();
      int lat, we, rq, sh; logic [31:0] rd; logic sv;
      run_xact(1'b1, 1'b1, 1'b1, 32'h24, 32'h5A5A_0001, 0, lat, rd, we, rq, sh, sv);
      ref_mem[9] = 32'h5A5A_0001;
      nvec++; if (we !== 1) begin nmis++; $display("FAIL rw_both_is_write we_cycles=%0d exp=1", we); end
      nvec++; if (mem_arr[9] !== ref_mem[9]) begin nmis++; $display("FAIL rw_both_mem got=%h exp=%h", mem_arr[9], ref_mem[9]); end
   endtask

   task automatic test_abort();
      int lat, we, rq, sh; logic [31:0] rd; logic sv;
      run_xact(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1000, lat, rd, we, rq, sh, sv);
      nvec++; if (lat !== WAIT_MAX + 2) begin nmis++; $display("FAIL abort_latency got=%0d exp=%0d", lat, WAIT_MAX + 2); end
      nvec++; if (rq !== WAIT_MAX + 1) begin nmis++; $display("FAIL abort_req_cycles got=%0d exp=%0d", rq, WAIT_MAX + 1); end
      nvec++; if (rd !== 32'h0) begin nmis++; $display("FAIL abort_rdata got=%h exp=0", rd); end
      nvec++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL abort_err got=%b exp=1", bus.err); end
      run_xact(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 0, lat, rd, we, rq, sh, sv);
      nvec++; if (rd !== ref_mem[17] || bus.err !== 1'b1) begin nmis++; $display("FAIL abort_err_sticky rd=%h err=%b exp rd=%h err=1", rd, bus.err, ref_mem[17]); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0; int lat, we, rq, sh; logic [31:0] rd; logic sv;
      rsp_wait = 1000;
      bus.d_read = 1'b1; bus.d_addr = 32'h48;
      repeat (3) @(posedge Eclk);
      #1;
      nvec++; if (bus.mem_req !== 1'b1) begin nmis++; $display("FAIL rstmid_in_access mem_req=%b exp=1", bus.mem_req); end
      Erst_n = 1'b0;
      #1;
      nvec++; if (bus.mem_req !== 1'b0 || bus.err !== 1'b0) begin nmis++; $display("FAIL rstmid_async mem_req=%b err=%b exp=0 0", bus.mem_req, bus.err); end
      bus.d_read = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (n == 2) Erst_n = 1'b1;
         @(posedge Eclk); #1;
         if (bus.d_valid || bus.mem_req) pulses++;
      end
      nvec++; if (pulses !== 0) begin nmis++; $display("FAIL rstmid_no_pulse got=%0d exp=0", pulses); end
      run_xact(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 1, lat, rd, we, rq, sh, sv);
      nvec++; if (lat !== 3 || rd !== ref_mem[18]) begin nmis++; $display("FAIL rstmid_after lat=%0d rd=%h exp lat=3 rd=%h", lat, rd, ref_mem[18]); end
   endtask

   task automatic test_d_during_i();
      int dv_n = -1, iv_n = -1; logic [31:0] drd = 32'h0, ird = 32'h0, maddr = 32'hx;
      rsp_wait = 3;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      for (int n = 1; n <= 30; n++) begin
         @(posedge Eclk); #1;
         if (n == 2) begin bus.d_read = 1'b1; bus.d_addr = 32'h40; end
         if (n == 3) maddr = bus.mem_addr;
         if (bus.if_valid && iv_n < 0) begin iv_n = n; ird = bus.if_rdata; bus.if_req = 1'b0; end
         if (bus.d_valid) begin dv_n = n; drd = bus.d_rdata; break; end
      end
      bus.d_read = 1'b0; bus.if_req = 1'b0;
      @(posedge Eclk); #1;
      nvec++; if (maddr !== 32'h10) begin nmis++; $display("FAIL dint_fetch_held addr=%h exp=10", maddr); end
      nvec++; if (iv_n !== 5 || ird !== ref_mem[4]) begin nmis++; $display("FAIL dint_fetch_done n=%0d rd=%h exp n=5 rd=%h", iv_n, ird, ref_mem[4]); end
      nvec++; if (dv_n !== 11 || drd !== ref_mem[16]) begin nmis++; $display("FAIL dint_data_next n=%0d rd=%h exp n=11 rd=%h", dv_n, drd, ref_mem[16]); end
      nvec++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL dint_no_abort err=%b exp=0", bus.err); end
   endtask

   task automatic test_random();
      int lat, we, rq, sh, kind, w; logic [31:0] rd, addr, wdata, prev; logic sv;
      for (int i = 0; i < 24; i++) begin
         kind  = $urandom_range(0, 2);
         addr  = 32'($urandom_range(0, 255)) << 2;
         wdata = $urandom;
         w     = $urandom_range(0, 6);
         prev  = bus.d_rdata;
         run_xact(kind != 0, kind == 1, kind == 2, addr, wdata, w, lat, rd, we, rq, sh, sv);
         nvec++; if (lat !== w + 2 || sv !== 1'b0) begin nmis++; $display("FAIL rnd_timing[%0d] lat=%0d stall=%b exp lat=%0d stall=0", i, lat, sv, w + 2); end
         if (kind == 2) begin
            ref_mem[addr[9:2]] = wdata;
            nvec++; if (rd !== prev || we !== w + 1) begin nmis++; $display("FAIL rnd_write[%0d] rd=%h we=%0d exp rd=%h we=%0d", i, rd, we, prev, w + 1); end
         end else begin
            nvec++; if (rd !== ref_mem[addr[9:2]]) begin nmis++; $display("FAIL rnd_read[%0d] kind=%0d addr=%h got=%h exp=%h", i, kind, addr, rd, ref_mem[addr[9:2]]); end
         end
      end
      nvec++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL rnd_err got=%b exp=0", bus.err); end
   endtask

   initial begin
      logic [31:0] v;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem_arr[i] = v;
         ref_mem[i] = v;
      end
      test_reset();
      test_fetch();
      test_priority();
      test_write_wait();
      test_read_write_both();
      test_abort();
      test_reset_mid();
      test_d_during_i();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
